// File: rtl/zrb_uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings and default sizing.
package zrb_uart_tx_arbiter_pkg;

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_ARB   = 3'd1;
  localparam logic [2:0] ENC_LOAD  = 3'd2;
  localparam logic [2:0] ENC_HOLD  = 3'd3;
  localparam logic [2:0] ENC_DRAIN = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ENC_IDLE,
    ST_ARB   = ENC_ARB,
    ST_LOAD  = ENC_LOAD,
    ST_HOLD  = ENC_HOLD,
    ST_DRAIN = ENC_DRAIN
  } arb_state_t;

  localparam int ARB_DATA_WIDTH   = 8;
  localparam int ARB_MAX_BURST    = 16;
  localparam int ARB_STALL_CYCLES = 1024;

endpackage

// File: rtl/zrb_rr_picker.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, wrapping.
module zrb_rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               any_valid
);

  int   idx;
  logic found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && valid[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    any_valid = |valid;
  end

endmodule

// File: rtl/zrb_uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional stall timeout and stall_abort port enabled by defining ZRB_ARB_STALL_TIMEOUT_EN.
module zrb_uart_tx_arbiter
  import zrb_uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = ARB_DATA_WIDTH,
  parameter int MAX_BURST    = ARB_MAX_BURST,
  parameter int STALL_CYCLES = ARB_STALL_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_write,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  output logic [NUM_REQ-1:0]            grant,
`ifdef ZRB_ARB_STALL_TIMEOUT_EN
  output logic                          stall_abort,
`endif
  output logic                          grant_valid
);

  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255 || STALL_CYCLES < 1 ||
      DATA_WIDTH != ARB_DATA_WIDTH) begin : g_bad_param
    $error("zrb_uart_tx_arbiter: parameter out of range");
  end

  arb_state_t           state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     owner_idx;
  logic [BURST_W-1:0]   burst_cnt;
  logic                 last_flag;

  logic [NUM_REQ-1:0]   winner;
  logic                 any_valid;
  logic [PTR_W-1:0]     winner_idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                 sel_last;
  logic                 xfer;
  logic                 owner_valid;
  logic [PTR_W-1:0]     next_ptr;

  zrb_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    winner_idx = '0;
    sel_data   = '0;
    sel_last   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) winner_idx = PTR_W'(i);
      if (grant[i]) begin
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last = req_last[i];
      end
    end
  end

  // Pop strobe is combinational so the requester FIFO sees it in the transfer cycle itself.
  assign req_ready   = req_valid & grant & {NUM_REQ{(state == ST_LOAD) && !tx_busy}};
  assign xfer        = |req_ready;
  assign owner_valid = |(req_valid & grant);
  assign next_ptr    = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);

`ifdef ZRB_ARB_STALL_TIMEOUT_EN
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      owner_idx   <= '0;
      burst_cnt   <= '0;
      last_flag   <= 1'b0;
      grant       <= '0;
      grant_valid <= 1'b0;
      tx_write    <= 1'b0;
      tx_data     <= '0;
`ifdef ZRB_ARB_STALL_TIMEOUT_EN
      stall_cnt   <= '0;
      stall_abort <= 1'b0;
`endif
    end else begin
      tx_write <= 1'b0;
`ifdef ZRB_ARB_STALL_TIMEOUT_EN
      stall_abort <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (|req_valid) state <= ST_ARB;
        end
        ST_ARB: begin
          if (any_valid) begin
            grant       <= winner;
            grant_valid <= 1'b1;
            owner_idx   <= winner_idx;
            burst_cnt   <= '0;
`ifdef ZRB_ARB_STALL_TIMEOUT_EN
            stall_cnt   <= '0;
`endif
            state       <= ST_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            tx_write  <= 1'b1;
            tx_data   <= sel_data;
            last_flag <= sel_last;
            burst_cnt <= burst_cnt + BURST_W'(1);
`ifdef ZRB_ARB_STALL_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            state     <= ST_HOLD;
          end
`ifdef ZRB_ARB_STALL_TIMEOUT_EN
          else if (!owner_valid && !tx_busy) begin
            if (stall_cnt == STALL_W'(STALL_CYCLES - 1)) begin
              stall_abort <= 1'b1;
              stall_cnt   <= '0;
              rr_ptr      <= next_ptr;
              grant       <= '0;
              grant_valid <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              stall_cnt <= stall_cnt + STALL_W'(1);
            end
          end
`endif
        end
        // The transmitter only raises busy one cycle after the write, so skip one cycle.
        ST_HOLD: begin
          state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!tx_busy) begin
            if (last_flag || burst_cnt == BURST_W'(MAX_BURST)) begin
              rr_ptr      <= next_ptr;
              grant       <= '0;
              grant_valid <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
